// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state/owner types and default widths for the memory port arbiter.
package mem_arb_pkg;
    typedef enum logic [1:0] {IDLE, REQ, RESP} arb_state_t;
    typedef enum logic {OWN_IFU, OWN_LSU} arb_owner_t;
    localparam int ARB_ADDR_W = 32;
    localparam int ARB_DATA_W = 32;
endpackage

// File: rtl/arb_priority_select.sv
// arb_priority_select: LSU-over-IFU winner pick with a streak counter that forces an IFU win.
module arb_priority_select #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_ifu_req,
    input  logic i_lsu_req,
    input  logic i_grant_en,
    output logic o_pick_ifu,
    output logic o_pick_lsu
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

    logic [SW-1:0] r_streak;
    logic          w_force_ifu;

    assign w_force_ifu = i_ifu_req && i_lsu_req && (r_streak == LIMIT);
    assign o_pick_lsu  = i_grant_en && i_lsu_req && !w_force_ifu;
    assign o_pick_ifu  = i_grant_en && i_ifu_req && !o_pick_lsu;

    // Only contested LSU wins build the streak; anything else breaks it.
    always_ff @(posedge i_clock) begin
        if (i_reset)
            r_streak <= '0;
        else if (o_pick_lsu)
            r_streak <= !i_ifu_req ? '0 : (r_streak == LIMIT) ? r_streak : r_streak + SW'(1);
        else if (o_pick_ifu)
            r_streak <= '0;
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between IFU and LSU, one transaction in flight.
// Optional performance counters are enabled with ARB_PERF_CNT_EN.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = ARB_ADDR_W,
    parameter int DATA_W       = ARB_DATA_W,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_ifu_req,
    input  logic [ADDR_W-1:0] i_ifu_addr,
    output logic              o_ifu_gnt,
    output logic              o_ifu_rvalid,
    output logic [DATA_W-1:0] o_ifu_rdata,
    input  logic              i_lsu_req,
    input  logic              i_lsu_we,
    input  logic [ADDR_W-1:0] i_lsu_addr,
    input  logic [DATA_W-1:0] i_lsu_wdata,
    input  logic [DATA_W/8-1:0] i_lsu_be,
    output logic              o_lsu_gnt,
    output logic              o_lsu_rvalid,
    output logic [DATA_W-1:0] o_lsu_rdata,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    output logic [DATA_W/8-1:0] o_mem_be,
    input  logic              i_mem_ready,
    input  logic              i_mem_rvalid,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic [31:0]       o_perf_ifu_stall,
    output logic [31:0]       o_perf_lsu_grants
);
    localparam int BE_W = DATA_W / 8;

    arb_state_t        r_state, w_state_nxt;
    arb_owner_t        r_owner;
    logic [ADDR_W-1:0] r_addr;
    logic              r_we;
    logic [DATA_W-1:0] r_wdata;
    logic [BE_W-1:0]   r_be;
    logic              w_pick_ifu, w_pick_lsu, w_grant, w_resp_valid;

    arb_priority_select #(.STARVE_LIMIT(STARVE_LIMIT)) u_sel (
        .i_clock    (i_clock),
        .i_reset    (i_reset),
        .i_ifu_req  (i_ifu_req),
        .i_lsu_req  (i_lsu_req),
        .i_grant_en (r_state == IDLE && !i_reset),
        .o_pick_ifu (w_pick_ifu),
        .o_pick_lsu (w_pick_lsu)
    );

    assign w_grant   = w_pick_ifu || w_pick_lsu;
    assign o_ifu_gnt = w_pick_ifu;
    assign o_lsu_gnt = w_pick_lsu;

    always_comb begin
        w_state_nxt = r_state;
        if (r_state == IDLE && w_grant)
            w_state_nxt = REQ;
        else if (r_state == REQ && i_mem_ready)
            w_state_nxt = RESP;
        else if (r_state == RESP && i_mem_rvalid)
            w_state_nxt = IDLE;
    end

    always_ff @(posedge i_clock) begin
        if (i_reset)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Fetches are always full-word reads.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_owner <= OWN_IFU;
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_wdata <= '0;
            r_be    <= '0;
        end else if (w_grant) begin
            r_owner <= w_pick_lsu ? OWN_LSU : OWN_IFU;
            r_addr  <= w_pick_lsu ? i_lsu_addr : i_ifu_addr;
            r_we    <= w_pick_lsu && i_lsu_we;
            r_wdata <= w_pick_lsu ? i_lsu_wdata : '0;
            r_be    <= w_pick_lsu ? i_lsu_be : '1;
        end
    end

    assign o_mem_req    = (r_state == REQ);
    assign o_mem_we     = r_we;
    assign o_mem_addr   = r_addr;
    assign o_mem_wdata  = r_wdata;
    assign o_mem_be     = r_be;
    assign w_resp_valid = (r_state == RESP) && i_mem_rvalid;
    assign o_ifu_rvalid = w_resp_valid && (r_owner == OWN_IFU);
    assign o_lsu_rvalid = w_resp_valid && (r_owner == OWN_LSU);
    assign o_ifu_rdata  = i_mem_rdata;
    assign o_lsu_rdata  = i_mem_rdata;

`ifdef ARB_PERF_CNT_EN
    logic [31:0] r_perf_ifu_stall, r_perf_lsu_grants;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_perf_ifu_stall  <= '0;
            r_perf_lsu_grants <= '0;
        end else begin
            if (i_ifu_req && !w_pick_ifu)
                r_perf_ifu_stall <= r_perf_ifu_stall + 32'd1;
            if (w_pick_lsu)
                r_perf_lsu_grants <= r_perf_lsu_grants + 32'd1;
        end
    end

    assign o_perf_ifu_stall  = r_perf_ifu_stall;
    assign o_perf_lsu_grants = r_perf_lsu_grants;
`else
    assign o_perf_ifu_stall  = '0;
    assign o_perf_lsu_grants = '0;
`endif
endmodule
